alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU (rs1/rs2/ctrl in; ALUoutput/zero out) between two requesters:

---
 rtl/alu_share_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between the execute stage (requester 0) and
// the branch/address unit (requester 1). Round-robin grant, one operation in
// flight, and a registered response held under valid/ready backpressure.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_rs1,
  output logic [WIDTH-1:0]  alu_rs2,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [WIDTH-1:0]  resp_data,
  output logic              resp_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q;
  logic               owner_q;
  logic               last_grant_q;
  logic [1:0]         resp_valid_q;
  logic [WIDTH-1:0]   resp_data_q;
  logic               resp_zero_q;

  logic               slot_free;
  logic               owner_drains;
  logic               gnt_valid;
  logic               gnt_idx;
  logic               accept;

  // The held response leaves only when its own owner takes it; the other
  // requester's resp_ready has no effect.
  assign owner_drains = (state_q == HOLD) && resp_ready[owner_q];
  assign slot_free    = (state_q == IDLE) || owner_drains;

  // Round-robin pick: on a tie, favour whoever was not granted last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    case (req_valid)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_idx   = ~last_grant_q;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
      end
    endcase
  end

  assign accept    = slot_free && gnt_valid;
  assign req_ready = accept ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  // Steer the granted requester's operands to the ALU; idle bus is all zero.
  always_comb begin
    alu_ctrl = '0;
    alu_rs1  = '0;
    alu_rs2  = '0;
    if (gnt_valid) begin
      if (gnt_idx) begin
        alu_ctrl = req1_ctrl;
        alu_rs1  = req1_a;
        alu_rs2  = req1_b;
      end else begin
        alu_ctrl = req0_ctrl;
        alu_rs1  = req0_a;
        alu_rs2  = req0_b;
      end
    end
  end

  // Response-slot FSM: capture on accept (also back-to-back while draining),
  // release to IDLE when the owner drains with nothing new accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
    end else if (accept) begin
      state_q      <= HOLD;
      owner_q      <= gnt_idx;
      last_grant_q <= gnt_idx;
      resp_valid_q <= gnt_idx ? 2'b10 : 2'b01;
      resp_data_q  <= alu_result;
      resp_zero_q  <= alu_zero;
    end else if (owner_drains) begin
      state_q      <= IDLE;
      resp_valid_q <= 2'b00;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a small ALU model drives alu_result, a
// scoreboard queues the expected response at each accepted request and
// retires it when the owner takes the response; directed sequences cover
// the arbitration and backpressure corner cases.
module tb_alu_share_arbiter;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] OP_AND = 4'd0;
  localparam logic [CTRL_W-1:0] OP_OR  = 4'd1;
  localparam logic [CTRL_W-1:0] OP_ADD = 4'd2;
  localparam logic [CTRL_W-1:0] OP_SUB = 4'd6;
  localparam logic [CTRL_W-1:0] OP_SLT = 4'd7;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_rs1, alu_rs2;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [WIDTH-1:0]  resp_data;
  logic              resp_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]       owner_oh;
    logic [WIDTH-1:0] data;
    logic             zero;
  } exp_t;

  exp_t sb[$];

  alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_ctrl  (req0_ctrl),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_ctrl  (req1_ctrl),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_ctrl   (alu_ctrl),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_f(input logic [CTRL_W-1:0] c,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (c)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  // Behavioural ALU sitting behind the arbiter.
  always_comb begin
    alu_result = alu_f(alu_ctrl, alu_rs1, alu_rs2);
    alu_zero   = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare the held response against the oldest queued entry,
  // retire it when its owner accepts, then queue newly accepted requests.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      check("rdy_exclusive", {63'd0, req_ready == 2'b11}, 64'd0);
      if (resp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_resp", {62'd0, resp_valid}, 64'd0);
        end else begin
          check("sb_owner", {62'd0, resp_valid}, {62'd0, sb[0].owner_oh});
          check("sb_data", {32'd0, resp_data}, {32'd0, sb[0].data});
          check("sb_zero", {63'd0, resp_zero}, {63'd0, sb[0].zero});
          if ((resp_ready & sb[0].owner_oh) != 2'b00) void'(sb.pop_front());
        end
      end else if (sb.size() != 0) begin
        check("sb_missing_resp", 64'(sb.size()), 64'd0);
        sb.delete();
      end
      if (req_valid[0] && req_ready[0]) begin
        exp_t e;
        e.owner_oh = 2'b01;
        e.data     = alu_f(req0_ctrl, req0_a, req0_b);
        e.zero     = (e.data == '0);
        sb.push_back(e);
      end
      if (req_valid[1] && req_ready[1]) begin
        exp_t e;
        e.owner_oh = 2'b10;
        e.data     = alu_f(req1_ctrl, req1_a, req1_b);
        e.zero     = (e.data == '0);
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [CTRL_W-1:0] c, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    req0_ctrl = c;
    req0_a    = a;
    req0_b    = b;
  endtask

  task automatic set_req1(input logic [CTRL_W-1:0] c, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    req1_ctrl = c;
    req1_a    = a;
    req1_b    = b;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [CTRL_W-1:0] ops [5];
    ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_SUB; ops[4] = OP_SLT;
    set_req0(OP_AND, '0, '0);
    set_req1(OP_AND, '0, '0);

    // Reset state and first single-requester ADD.
    do_reset();
    #1;
    check("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
    check("rst_resp_data", {32'd0, resp_data}, 64'd0);
    check("rst_resp_zero", {63'd0, resp_zero}, 64'd0);
    check("rst_req_ready", {62'd0, req_ready}, 64'd0);
    set_req0(OP_ADD, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1;
    check("t1_req_ready", {62'd0, req_ready}, 64'd1);
    check("t1_alu_rs1", {32'd0, alu_rs1}, 64'd5);
    tick();
    req_valid = 2'b00;
    #1;
    check("t1_resp_valid", {62'd0, resp_valid}, 64'd1);
    check("t1_resp_data", {32'd0, resp_data}, 64'd12);
    check("t1_resp_zero", {63'd0, resp_zero}, 64'd0);
    check("t1_no_req_alu_zero", {28'd0, alu_ctrl, alu_rs1}, 64'd0);
    resp_ready = 2'b01;
    tick();
    #1;
    check("t1_drained", {62'd0, resp_valid}, 64'd0);

    // Continuous tie with full drain: strict alternation 0,1,0,1.
    do_reset();
    resp_ready = 2'b11;
    req_valid  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      set_req0(ops[$urandom_range(0, 4)], $urandom, $urandom);
      set_req1(ops[$urandom_range(0, 4)], $urandom, $urandom);
      #1;
      check($sformatf("t2_grant%0d", k), {62'd0, req_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k > 0)
        check($sformatf("t2_resp%0d", k), {62'd0, resp_valid}, (k % 2 == 1) ? 64'd1 : 64'd2);
      tick();
    end
    req_valid = 2'b00;
    #1;
    check("t2_last_resp", {62'd0, resp_valid}, 64'd2);
    tick();
    #1;
    check("t2_idle", {62'd0, resp_valid}, 64'd0);

    // Owner 1 stalls its response for three cycles.
    set_req1(OP_OR, 32'h100, 32'h23);
    resp_ready = 2'b00;
    req_valid  = 2'b10;
    #1;
    check("t3_accept1", {62'd0, req_ready}, 64'd2);
    tick();
    set_req0(OP_ADD, 32'd3, 32'd4);
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t3_hold_valid%0d", k), {62'd0, resp_valid}, 64'd2);
      check($sformatf("t3_hold_data%0d", k), {32'd0, resp_data}, 64'h123);
      check($sformatf("t3_hold_rdy%0d", k), {62'd0, req_ready}, 64'd0);
      tick();
    end
    resp_ready = 2'b10;
    #1;
    check("t3_next_grant0", {62'd0, req_ready}, 64'd1);
    tick();
    #1;
    check("t3_resp0_valid", {62'd0, resp_valid}, 64'd1);
    check("t3_resp0_data", {32'd0, resp_data}, 64'd7);

    // Non-owner ready ignored, then same-edge replacement.
    resp_ready = 2'b10;
    req_valid  = 2'b11;
    #1;
    check("t4_nonowner_rdy", {62'd0, req_ready}, 64'd0);
    tick();
    #1;
    check("t4_still_held", {62'd0, resp_valid}, 64'd1);
    set_req1(OP_SUB, 32'd10, 32'd1);
    resp_ready = 2'b01;
    req_valid  = 2'b10;
    #1;
    check("t4_b2b_rdy", {62'd0, req_ready}, 64'd2);
    tick();
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    #1;
    check("t4_replaced_valid", {62'd0, resp_valid}, 64'd2);
    check("t4_replaced_data", {32'd0, resp_data}, 64'd9);
    tick();
    #1;
    check("t4_idle", {62'd0, resp_valid}, 64'd0);

    // Zero flag and 32-bit wrap.
    set_req0(OP_SUB, 32'h1234, 32'h1234);
    resp_ready = 2'b00;
    req_valid  = 2'b01;
    tick();
    set_req0(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    resp_ready = 2'b01;
    #1;
    check("t5_sub_zero", {63'd0, resp_zero}, 64'd1);
    check("t5_sub_data", {32'd0, resp_data}, 64'd0);
    check("t5_b2b_rdy", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    #1;
    check("t5_wrap_valid", {62'd0, resp_valid}, 64'd1);
    check("t5_wrap_data", {32'd0, resp_data}, 64'd0);
    check("t5_wrap_zero", {63'd0, resp_zero}, 64'd1);
    tick();
    #1;
    check("t5_idle", {62'd0, resp_valid}, 64'd0);

    // Reset while holding a response.
    set_req1(OP_ADD, 32'd1, 32'd1);
    resp_ready = 2'b00;
    req_valid  = 2'b10;
    tick();
    req_valid = 2'b00;
    #1;
    check("t6_held", {62'd0, resp_valid}, 64'd2);
    rst = 1'b1;
    tick();
    #1;
    check("t6_rst_valid", {62'd0, resp_valid}, 64'd0);
    check("t6_rst_data", {32'd0, resp_data}, 64'd0);
    rst       = 1'b0;
    req_valid = 2'b11;
    #1;
    check("t6_first_tie", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    #1;
    check("t6_resp_valid", {62'd0, resp_valid}, 64'd1);
    tick();

    // Random traffic; the scoreboard does the checking.
    for (int k = 0; k < 400; k++) begin
      req_valid  = 2'($urandom);
      resp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      set_req0(ops[$urandom_range(0, 4)], $urandom, $urandom);
      set_req1(ops[$urandom_range(0, 4)], $urandom, $urandom);
      if ($urandom_range(0, 7) == 0) set_req0(OP_SUB, req0_a, req0_a);
      tick();
    end
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    tick();
    tick();
    #1;
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    check("final_idle", {62'd0, resp_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
